// File: rtl/vram_scanout_arbiter.sv
// vram_scanout_arbiter
//   Shares one single-port video RAM between VGA scanout prefetch and a host
//   port, granting at most one access per cycle. Video reads fill a pixel FIFO
//   whose head drives the RGB332 output. Host reads and writes use a req/ack
//   handshake.
//
// Ports
//   i_vgaclk, i_reset       pixel clock, synchronous active-high reset
//   i_frame_start           flush FIFO and restart fetch at i_fb_base
//   i_fb_base, i_frame_pixels  frame fetch window, sampled on i_frame_start
//   i_pix_pop               consume FIFO head
//   o_pix_data, o_underflow FIFO head byte (0 when empty), sticky underflow
//   i_host_req/we/addr/wdat host request, held until o_host_ack
//   o_host_ack, o_host_rdat one-cycle completion pulse with read data
//   o_mem_en/we/addr/wdat   VRAM command for this cycle
//   i_mem_rdat              VRAM read data, MEM_LAT cycles after issue
module vram_scanout_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic        i_vgaclk,
    input  logic        i_reset,
    input  logic        i_frame_start,
    input  logic [23:0] i_fb_base,
    input  logic [23:0] i_frame_pixels,
    input  logic        i_pix_pop,
    output logic [7:0]  o_pix_data,
    output logic        o_underflow,
    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [23:0] i_host_addr,
    input  logic [7:0]  i_host_wdat,
    output logic        o_host_ack,
    output logic [7:0]  o_host_rdat,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [23:0] o_mem_addr,
    output logic [7:0]  o_mem_wdat,
    input  logic [7:0]  i_mem_rdat
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] LOW_WM_V = OW'(LOW_WM);
    localparam logic [OW-1:0] DEPTH_V  = OW'(FIFO_DEPTH);

    typedef enum logic {H_IDLE, H_BUSY} host_state_t;

    host_state_t        host_state, host_state_next;
    logic               host_is_write;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      fifo_count, inflight_video, drop_count;
    logic [23:0]        fetch_addr, remaining;
    logic [MEM_LAT-1:0] tag_valid, tag_video;
    logic               underflow_q;

    logic [OW-1:0] occupancy;
    logic          have_work, urgent, host_ok;
    logic          grant_video, grant_host, issue_read;
    logic          ret_video, ret_host, push, pop, host_ack;

    // Occupancy counts reserved slots too, so a video read only issues when
    // its data is guaranteed a FIFO entry on return.
    assign occupancy   = {1'b0, fifo_count} + {1'b0, inflight_video};
    assign have_work   = (remaining != 24'd0) && !i_frame_start && !i_reset;
    assign urgent      = have_work && (occupancy < LOW_WM_V);
    assign host_ok     = i_host_req && (host_state == H_IDLE) && !i_reset;
    assign grant_host  = host_ok && !urgent;
    assign grant_video = urgent || (!host_ok && have_work && (occupancy < DEPTH_V));
    assign issue_read  = grant_video || (grant_host && !i_host_we);

    // The last tag stage marks the cycle the read data is on i_mem_rdat.
    assign ret_video = tag_valid[MEM_LAT-1] && tag_video[MEM_LAT-1];
    assign ret_host  = tag_valid[MEM_LAT-1] && !tag_video[MEM_LAT-1];
    assign push      = ret_video && (drop_count == '0) && !i_frame_start;
    assign pop       = i_pix_pop && (fifo_count != '0) && !i_frame_start;

    assign o_mem_en    = grant_video || grant_host;
    assign o_mem_we    = grant_host && i_host_we;
    assign o_mem_addr  = grant_video ? fetch_addr : (grant_host ? i_host_addr : 24'd0);
    assign o_mem_wdat  = o_mem_we ? i_host_wdat : 8'd0;
    assign o_pix_data  = (fifo_count != '0) ? fifo_mem[rd_ptr] : 8'd0;
    assign o_underflow = underflow_q;
    assign o_host_ack  = host_ack;
    assign o_host_rdat = (host_ack && !host_is_write) ? i_mem_rdat : 8'd0;

    // NOTE: every signal is given a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        host_state_next = host_state;
        host_ack        = 1'b0;
        case (host_state)
            H_IDLE: if (grant_host) host_state_next = H_BUSY;
            H_BUSY: begin
                // A write completes one cycle after grant; a read waits for
                // its tag to reach the end of the return pipeline.
                if ((host_is_write || ret_host) && !i_reset) begin
                    host_ack        = 1'b1;
                    host_state_next = H_IDLE;
                end
            end
            default: host_state_next = H_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset) begin
            host_state     <= H_IDLE;
            host_is_write  <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            inflight_video <= '0;
            drop_count     <= '0;
            fetch_addr     <= 24'd0;
            remaining      <= 24'd0;
            tag_valid      <= '0;
            tag_video      <= '0;
            underflow_q    <= 1'b0;
        end else begin
            host_state <= host_state_next;
            if (grant_host) host_is_write <= i_host_we;

            tag_valid[0] <= issue_read;
            tag_video[0] <= grant_video;
            for (int k = 1; k < MEM_LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_video[k] <= tag_video[k-1];
            end

            case ({grant_video, ret_video})
                2'b10:   inflight_video <= inflight_video + CW'(1);
                2'b01:   inflight_video <= inflight_video - CW'(1);
                default: inflight_video <= inflight_video;
            endcase

            if (i_frame_start) begin
                fetch_addr  <= i_fb_base;
                remaining   <= i_frame_pixels;
                // Everything still outstanding after this cycle belongs to the
                // old frame; a return landing this cycle is discarded by push.
                drop_count  <= ret_video ? inflight_video - CW'(1) : inflight_video;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                fifo_count  <= '0;
                underflow_q <= 1'b0;
            end else begin
                if (grant_video) begin
                    fetch_addr <= fetch_addr + 24'd1;
                    remaining  <= remaining - 24'd1;
                end
                if (ret_video && (drop_count != '0)) drop_count <= drop_count - CW'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CW'(1);
                    2'b01:   fifo_count <= fifo_count - CW'(1);
                    default: fifo_count <= fifo_count;
                endcase
                if (i_pix_pop && (fifo_count == '0)) underflow_q <= 1'b1;
            end
        end
    end

    // NOTE: the FIFO storage is not reset; fifo_count gates every read of it,
    // so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge i_vgaclk) begin
        if (push) fifo_mem[wr_ptr] <= i_mem_rdat;
    end

endmodule
